if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 118 +++++++++++
 tb/tb_if_stage.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register with supervisor-bit protection and
// the IF/ID pipeline register, with stall, flush and bubble insertion.
// Optional feature macro: IF_ALIGN_CHECK_EN. When it is defined, a misaligned
// next-PC redirects fetch to 0x80000008, pulses AlignErr for one cycle and
// inserts a bubble. When it is undefined, the low two bits of the next-PC
// are cleared and AlignErr is tied low.
module if_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PCnext,
  input  logic [31:0] Instruction,
  input  logic        Stall,
  input  logic        Flush,
  output logic [31:0] PC,
  output logic [31:0] PCplus4,
  output logic [31:0] IF_ID_Instr,
  output logic [31:0] IF_ID_PCplus4,
  output logic        IF_ID_Valid,
  output logic        AlignErr
);

  localparam logic [31:0] RESET_PC      = 32'h8000_0000;
  localparam logic [31:0] TRAP_ENTRY_A  = 32'h8000_0004;
  localparam logic [31:0] TRAP_ENTRY_B  = 32'h8000_0008;
  localparam logic [31:0] ALIGN_TRAP_PC = 32'h8000_0008;

  logic [31:0] r_pc;
  logic [31:0] r_ifid_instr;
  logic [31:0] r_ifid_pcplus4;
  logic        r_ifid_valid;

  logic [31:0] w_pcplus4;
  logic [31:0] w_prot_pc;
  logic [31:0] w_pc_load;
  logic        w_align_bad;

  // The increment wraps inside the low 31 bits; the supervisor bit is never
  // changed by sequential fetch.
  assign w_pcplus4 = {r_pc[31], r_pc[30:0] + 31'd4};

  // User-mode code may not raise the supervisor bit, except by jumping to
  // one of the two trap entry points.
  always_comb begin
    w_prot_pc = PCnext;
    if (!r_pc[31] && (PCnext != TRAP_ENTRY_A) && (PCnext != TRAP_ENTRY_B)) begin
      w_prot_pc = {1'b0, PCnext[30:0]};
    end
  end

`ifdef IF_ALIGN_CHECK_EN
  logic r_align_err;

  // A misaligned target is replaced by the alignment trap vector. An error
  // is only taken on an edge where the PC really advances.
  always_comb begin
    w_align_bad = 1'b0;
    w_pc_load   = w_prot_pc;
    if (w_prot_pc[1:0] != 2'b00) begin
      w_align_bad = !Stall;
      w_pc_load   = ALIGN_TRAP_PC;
    end
  end

  // One-cycle error pulse for the edge that took the alignment trap.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_align_err <= 1'b0;
    end else begin
      r_align_err <= w_align_bad;
    end
  end

  assign AlignErr = r_align_err;
`else
  // Without the check, the target is silently word-aligned.
  always_comb begin
    w_align_bad = 1'b0;
    w_pc_load   = w_prot_pc & 32'hFFFF_FFFC;
  end

  assign AlignErr = 1'b0;
`endif

  // PC register: advances unless stalled.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, matching real flip-flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else if (!Stall) begin
      r_pc <= w_pc_load;
    end
  end

  // IF/ID register: a bubble (flush or alignment trap) wins over a stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ifid_instr   <= 32'h0;
      r_ifid_pcplus4 <= 32'h0;
      r_ifid_valid   <= 1'b0;
    end else if (Flush || w_align_bad) begin
      r_ifid_instr   <= 32'h0;
      r_ifid_pcplus4 <= 32'h0;
      r_ifid_valid   <= 1'b0;
    end else if (!Stall) begin
      r_ifid_instr   <= Instruction;
      r_ifid_pcplus4 <= w_pcplus4;
      r_ifid_valid   <= 1'b1;
    end
  end

  assign PC            = r_pc;
  assign PCplus4       = w_pcplus4;
  assign IF_ID_Instr   = r_ifid_instr;
  assign IF_ID_PCplus4 = r_ifid_pcplus4;
  assign IF_ID_Valid   = r_ifid_valid;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios with literal
// expectations, followed by randomized traffic, all compared every cycle
// against a behavioural model of the fetch stage.
module tb_if_stage;

  logic        clk;
  logic        reset;
  logic [31:0] PCnext;
  logic [31:0] Instruction;
  logic        Stall;
  logic        Flush;
  logic [31:0] PC;
  logic [31:0] PCplus4;
  logic [31:0] IF_ID_Instr;
  logic [31:0] IF_ID_PCplus4;
  logic        IF_ID_Valid;
  logic        AlignErr;

  if_stage dut (
    .clk           (clk),
    .reset         (reset),
    .PCnext        (PCnext),
    .Instruction   (Instruction),
    .Stall         (Stall),
    .Flush         (Flush),
    .PC            (PC),
    .PCplus4       (PCplus4),
    .IF_ID_Instr   (IF_ID_Instr),
    .IF_ID_PCplus4 (IF_ID_PCplus4),
    .IF_ID_Valid   (IF_ID_Valid),
    .AlignErr      (AlignErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

`ifdef IF_ALIGN_CHECK_EN
  localparam bit ALIGN_CHECK = 1'b1;
`else
  localparam bit ALIGN_CHECK = 1'b0;
`endif

  // Behavioural model state: what each output must be after the last edge.
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_pcp4;
  logic        m_valid;
  logic        m_aerr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Sequential fetch address: add four, wrap within 2^31, keep the mode bit.
  function automatic logic [31:0] seq_next(input logic [31:0] pc);
    logic [31:0] mode;
    logic [31:0] low;
    mode = pc & 32'h8000_0000;
    low  = (pc + 32'd4) & 32'h7FFF_FFFF;
    return mode | low;
  endfunction

  // Target actually allowed from the current mode.
  function automatic logic [31:0] allowed_target(input logic [31:0] pc, input logic [31:0] want);
    if (pc >= 32'h8000_0000) return want;
    if (want == 32'h8000_0004 || want == 32'h8000_0008) return want;
    return want % 32'h8000_0000;
  endfunction

  // Advance the model by one rising edge given the inputs held across it.
  task automatic model_step();
    logic [31:0] tgt;
    logic [31:0] new_pc;
    logic        trap;
    if (reset) begin
      m_pc = 32'h8000_0000; m_instr = 0; m_pcp4 = 0; m_valid = 0; m_aerr = 0;
    end else begin
      tgt  = allowed_target(m_pc, PCnext);
      trap = 1'b0;
      if (tgt % 4 != 0) begin
        if (ALIGN_CHECK) begin
          trap   = !Stall;
          new_pc = 32'h8000_0008;
        end else begin
          new_pc = tgt - (tgt % 4);
        end
      end else begin
        new_pc = tgt;
      end
      if (Flush || trap) begin
        m_instr = 0; m_pcp4 = 0; m_valid = 0;
      end else if (!Stall) begin
        m_instr = Instruction; m_pcp4 = seq_next(m_pc); m_valid = 1;
      end
      if (!Stall) m_pc = new_pc;
      m_aerr = trap;
    end
  endtask

  // Apply one set of inputs, let one edge pass, and land on the next falling edge.
  task automatic cycle(input logic rst, input logic [31:0] pcn, input logic [31:0] ins,
                       input logic st, input logic fl);
    reset = rst; PCnext = pcn; Instruction = ins; Stall = st; Flush = fl;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  // Compare every output with the model on each falling edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("pc",        PC,                    m_pc);
      check("pcplus4",   PCplus4,               seq_next(m_pc));
      check("ifid_instr", IF_ID_Instr,          m_instr);
      check("ifid_pcp4", IF_ID_PCplus4,         m_pcp4);
      check("ifid_valid", {31'h0, IF_ID_Valid}, {31'h0, m_valid});
      check("align_err", {31'h0, AlignErr},     {31'h0, m_aerr});
    end
  end

  initial begin
    logic [31:0] pcn;
    int unsigned sel;

    // Reset with stall and flush asserted must still initialise everything.
    cycle(1'b1, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 1'b1);
    cmp_en = 1'b1;
    cycle(1'b1, 32'h0000_0003, 32'h1234_5678, 1'b0, 1'b0);
    check("lit_reset_pc",    PC, 32'h8000_0000);
    check("lit_reset_valid", {31'h0, IF_ID_Valid}, 32'h0);

    // Free-run fetch from the reset vector.
    cycle(1'b0, seq_next(m_pc), 32'h2008_0001, 1'b0, 1'b0);
    check("lit_run_pc1",    PC,            32'h8000_0004);
    check("lit_run_instr",  IF_ID_Instr,   32'h2008_0001);
    check("lit_run_pcp4",   IF_ID_PCplus4, 32'h8000_0004);
    check("lit_run_valid",  {31'h0, IF_ID_Valid}, 32'h1);
    cycle(1'b0, seq_next(m_pc), 32'h2008_0001, 1'b0, 1'b0);
    check("lit_run_pc2",    PC,            32'h8000_0008);
    check("lit_run_pcp4b",  IF_ID_PCplus4, 32'h8000_0008);

    // User mode cannot raise the supervisor bit except at trap entries.
    cycle(1'b0, 32'h0040_0000, 32'h0000_0011, 1'b0, 1'b0);
    check("lit_user_enter", PC, 32'h0040_0000);
    cycle(1'b0, 32'h8000_1000, 32'h0000_0022, 1'b0, 1'b0);
    check("lit_user_prot",  PC, 32'h0000_1000);
    cycle(1'b0, 32'h8000_0004, 32'h0000_0033, 1'b0, 1'b0);
    check("lit_trap_entry", PC, 32'h8000_0004);

    // Stall holds everything; stall with flush holds PC and bubbles IF/ID.
    cycle(1'b0, 32'h0040_0010, 32'h0000_0044, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, $urandom & 32'hFFFF_FFFC, $urandom, 1'b1, 1'b0);
      check("lit_stall_pc", PC, 32'h0040_0010);
      check("lit_stall_pcp4", IF_ID_PCplus4, 32'h8000_0008);
    end
    cycle(1'b0, 32'h0000_1000, 32'h0000_0055, 1'b1, 1'b1);
    check("lit_sf_pc",    PC,          32'h0040_0010);
    check("lit_sf_instr", IF_ID_Instr, 32'h0);
    check("lit_sf_valid", {31'h0, IF_ID_Valid}, 32'h0);

    // PCplus4 wrap boundaries.
    cycle(1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
    cycle(1'b0, 32'hFFFF_FFFC, 32'h0000_0066, 1'b0, 1'b0);
    check("lit_wrap_kernel", PCplus4, 32'h8000_0000);
    cycle(1'b0, 32'h7FFF_FFFC, 32'h0000_0077, 1'b0, 1'b0);
    check("lit_wrap_user",   PCplus4, 32'h0000_0000);

    // Misaligned target in kernel mode.
    cycle(1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
    cycle(1'b0, 32'h8000_0102, 32'h0000_0088, 1'b0, 1'b0);
    if (ALIGN_CHECK) begin
      check("lit_align_pc",    PC, 32'h8000_0008);
      check("lit_align_err",   {31'h0, AlignErr},    32'h1);
      check("lit_align_valid", {31'h0, IF_ID_Valid}, 32'h0);
      cycle(1'b0, seq_next(m_pc), 32'h0000_0099, 1'b0, 1'b0);
      check("lit_align_pulse", {31'h0, AlignErr},    32'h0);
    end else begin
      check("lit_align_pc",  PC, 32'h8000_0100);
      check("lit_align_err", {31'h0, AlignErr}, 32'h0);
    end

    // Mid-run reset with stall and flush asserted.
    cycle(1'b0, 32'h8000_0200, 32'h0000_00AA, 1'b0, 1'b0);
    cycle(1'b1, 32'h8000_0300, 32'h0000_00BB, 1'b1, 1'b1);
    check("lit_midreset_pc",    PC, 32'h8000_0000);
    check("lit_midreset_valid", {31'h0, IF_ID_Valid}, 32'h0);
    check("lit_midreset_aerr",  {31'h0, AlignErr},    32'h0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      sel = $urandom_range(0, 99);
      if (sel < 35)      pcn = seq_next(m_pc);
      else if (sel < 45) pcn = ($urandom_range(0, 1) == 0) ? 32'h8000_0004 : 32'h8000_0008;
      else if (sel < 60) pcn = $urandom;
      else if (sel < 75) pcn = $urandom & 32'h7FFF_FFFC;
      else if (sel < 85) pcn = $urandom | 32'h8000_0000;
      else               pcn = {($urandom_range(0, 1) == 0) ? 1'b0 : 1'b1, 29'h1FFF_FFFF, 2'b00};
      cycle(($urandom_range(0, 99) < 2), pcn, $urandom,
            ($urandom_range(0, 99) < 20), ($urandom_range(0, 99) < 10));
    end

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
